// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM state encoding
// and default geometry of the PC datapath.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam int             XLEN_DEF     = 64;
  localparam logic [63:0]    PC_LIMIT_DEF = 64'h200;
  localparam int             CNT_W_DEF    = 32;
  localparam int             INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holding register for a branch redirect that could not be applied because
// instruction memory was busy. A load always overrides an older entry and
// wins over a simultaneous clear.
module pc_redirect_buf #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_target,
  input  logic            clear,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  // Pending-redirect register: newest load wins, clear consumes the entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (load) begin
      pend_valid  <= 1'b1;
      pend_target <= load_target;
    end else if (clear) begin
      pend_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer. Chooses hold / +4 / branch-target for the PC
// register each cycle, arbitrating EX redirects, load-use stalls and
// instruction-memory wait states, and halts at the end of the program.
// Outputs are a Mealy decode of the state register and current inputs.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] PC_LIMIT = XLEN'(PC_LIMIT_DEF),
  parameter int              CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_cur,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             hz_stall,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic [XLEN-1:0]  pc_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  // Last address that may still be fetched sequentially is PC_LIMIT-4.
  localparam logic [XLEN-1:0] LAST_SEQ = PC_LIMIT - XLEN'(INSTR_BYTES);

  state_t            state;
  state_t            next_state;
  logic              pend_valid;
  logic [XLEN-1:0]   pend_target;
  logic              buf_load;
  logic              buf_clear;
  logic              cnt_inc;
  logic              redirect_req;
  logic [XLEN-1:0]   redirect_target;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A fresh branch always beats the one parked in the holding register.
  assign redirect_req    = br_taken | pend_valid;
  assign redirect_target = br_taken ? br_target : pend_target;

  pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (buf_load),
    .load_target (br_target),
    .clear       (buf_clear),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

  // State register; reset lands in IDLE so every output decodes to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Committed-redirect counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         redirect_cnt <= '0;
    else if (cnt_inc) redirect_cnt <= sat_inc(redirect_cnt);
  end

  // Next-state and output decode
  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    cnt_inc     = 1'b0;

    unique case (state)
      IDLE: next_state = RUN;

      // A late branch while halted is handled exactly like RUN; with no
      // pending entry in HALT it always hits one of the redirect arms.
      RUN, HALT: begin
        if (state == HALT && !br_taken) begin
          halted = 1'b1;
        end else if (redirect_req && imem_ready) begin
          pc_write    = 1'b1;
          pc_src      = 1'b1;
          pc_target   = redirect_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          buf_clear   = 1'b1;
          cnt_inc     = 1'b1;
          next_state  = RUN;
        end else if (br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          buf_load    = 1'b1;
          next_state  = WAIT_MEM;
        end else if (hz_stall) begin
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          next_state = WAIT_MEM;
        end else if (pc_cur < LAST_SEQ) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end else begin
          next_state = HALT;
        end
      end

      // Hold fetch; park any branch, the newest overwriting older ones.
      WAIT_MEM: begin
        if (br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          buf_load    = 1'b1;
        end
        if (imem_ready) next_state = RUN;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Inputs change just after the falling
// edge and outputs are sampled 2 ns later, well away from the rising edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_cur;
  logic        br_taken;
  logic [63:0] br_target;
  logic        hz_stall;
  logic        imem_ready;
  logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, halted;
  logic [63:0] pc_target;
  logic [31:0] redirect_cnt;
  logic [5:0]  ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, halted};

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur       (pc_cur),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .hz_stall     (hz_stall),
    .imem_ready   (imem_ready),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .halted       (halted),
    .redirect_cnt (redirect_cnt)
  );

  // Advance one clock and apply the next input vector, then let it settle.
  task automatic step(input logic bt, input logic [63:0] tgt, input logic hz,
                      input logic rdy, input logic [63:0] pc);
    @(negedge clk);
    br_taken = bt; br_target = tgt; hz_stall = hz; imem_ready = rdy; pc_cur = pc;
    #2;
  endtask

  // ctl = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, halted}
  task automatic test_reset;
    rst = 1'b0; br_taken = 1'b1; br_target = 64'h40; hz_stall = 1'b0;
    imem_ready = 1'b1; pc_cur = 64'h0;
    #2;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 6'b000000); end
    checks++; if (pc_target !== 64'h0) begin failures++; $display("FAIL rst_target got=%h exp=0", pc_target); end
    checks++; if (redirect_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", redirect_cnt); end
    @(negedge clk);
    rst = 1'b1; br_taken = 1'b0; br_target = 64'h0;
    #2;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 6'b000000); end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 64'h0, 1'b0, 1'b1, 64'(i * 4));
      checks++; if (ctl !== 6'b101000) begin failures++; $display("FAIL seq%0d got=%b exp=%b", i, ctl, 6'b101000); end
      checks++; if (pc_target !== 64'h0) begin failures++; $display("FAIL seq%0d_target got=%h exp=0", i, pc_target); end
    end
  endtask

  task automatic test_redirect_beats_stall;
    step(1'b1, 64'h40, 1'b1, 1'b1, 64'hC);
    checks++; if (ctl !== 6'b110110) begin failures++; $display("FAIL redir_ctl got=%b exp=%b", ctl, 6'b110110); end
    checks++; if (pc_target !== 64'h40) begin failures++; $display("FAIL redir_target got=%h exp=40", pc_target); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h40);
    checks++; if (redirect_cnt !== 32'd1) begin failures++; $display("FAIL redir_cnt got=%0d exp=1", redirect_cnt); end
    checks++; if (ctl !== 6'b101000) begin failures++; $display("FAIL redir_after got=%b exp=%b", ctl, 6'b101000); end
  endtask

  task automatic test_hz_stall;
    step(1'b0, 64'h0, 1'b1, 1'b1, 64'h44);
    checks++; if (ctl !== 6'b000010) begin failures++; $display("FAIL hz_ctl got=%b exp=%b", ctl, 6'b000010); end
  endtask

  task automatic test_wait_mem;
    step(1'b1, 64'h80, 1'b0, 1'b0, 64'h44);
    checks++; if (ctl !== 6'b000110) begin failures++; $display("FAIL wm_br got=%b exp=%b", ctl, 6'b000110); end
    checks++; if (pc_target !== 64'h0) begin failures++; $display("FAIL wm_br_target got=%h exp=0", pc_target); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 64'h0, 1'b0, (i == 2), 64'h44);
      checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL wm_hold%0d got=%b exp=%b", i, ctl, 6'b000000); end
    end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h44);
    checks++; if (ctl !== 6'b110110) begin failures++; $display("FAIL wm_apply got=%b exp=%b", ctl, 6'b110110); end
    checks++; if (pc_target !== 64'h80) begin failures++; $display("FAIL wm_apply_target got=%h exp=80", pc_target); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h80);
    checks++; if (redirect_cnt !== 32'd2) begin failures++; $display("FAIL wm_cnt got=%0d exp=2", redirect_cnt); end
    checks++; if (ctl !== 6'b101000) begin failures++; $display("FAIL wm_drained got=%b exp=%b", ctl, 6'b101000); end
  endtask

  task automatic test_back_to_back;
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h84);
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL b2b_enter got=%b exp=%b", ctl, 6'b000000); end
    step(1'b1, 64'h80, 1'b0, 1'b0, 64'h84);
    checks++; if (ctl !== 6'b000110) begin failures++; $display("FAIL b2b_first got=%b exp=%b", ctl, 6'b000110); end
    step(1'b1, 64'hC0, 1'b0, 1'b0, 64'h84);
    checks++; if (ctl !== 6'b000110) begin failures++; $display("FAIL b2b_second got=%b exp=%b", ctl, 6'b000110); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h84);
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL b2b_ready got=%b exp=%b", ctl, 6'b000000); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h84);
    checks++; if (pc_target !== 64'hC0) begin failures++; $display("FAIL b2b_target got=%h exp=c0", pc_target); end
    checks++; if (ctl !== 6'b110110) begin failures++; $display("FAIL b2b_apply got=%b exp=%b", ctl, 6'b110110); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'hC0);
    checks++; if (redirect_cnt !== 32'd3) begin failures++; $display("FAIL b2b_cnt got=%0d exp=3", redirect_cnt); end
  endtask

  task automatic test_halt;
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h1F8);
    checks++; if (ctl !== 6'b101000) begin failures++; $display("FAIL halt_last got=%b exp=%b", ctl, 6'b101000); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h1FC);
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL halt_limit got=%b exp=%b", ctl, 6'b000000); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 64'h0, 1'b0, 1'b1, 64'h1FC);
      checks++; if (ctl !== 6'b000001) begin failures++; $display("FAIL halt_hold%0d got=%b exp=%b", i, ctl, 6'b000001); end
    end
    step(1'b1, 64'h10, 1'b0, 1'b1, 64'h1FC);
    checks++; if (ctl !== 6'b110110) begin failures++; $display("FAIL halt_br got=%b exp=%b", ctl, 6'b110110); end
    checks++; if (pc_target !== 64'h10) begin failures++; $display("FAIL halt_br_target got=%h exp=10", pc_target); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h10);
    checks++; if (ctl !== 6'b101000) begin failures++; $display("FAIL halt_resume got=%b exp=%b", ctl, 6'b101000); end
    checks++; if (redirect_cnt !== 32'd4) begin failures++; $display("FAIL halt_cnt got=%0d exp=4", redirect_cnt); end
  endtask

  task automatic test_reset_mid_wait;
    step(1'b1, 64'h100, 1'b0, 1'b0, 64'h14);
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h14);
    rst = 1'b0;
    #1;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL mid_rst_ctl got=%b exp=%b", ctl, 6'b000000); end
    checks++; if (redirect_cnt !== 32'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", redirect_cnt); end
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b1; pc_cur = 64'h0;
    #2;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL mid_idle got=%b exp=%b", ctl, 6'b000000); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    checks++; if (ctl !== 6'b101000) begin failures++; $display("FAIL mid_no_stale got=%b exp=%b", ctl, 6'b101000); end
    checks++; if (pc_target !== 64'h0) begin failures++; $display("FAIL mid_target got=%h exp=0", pc_target); end
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h4);
    checks++; if (redirect_cnt !== 32'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", redirect_cnt); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_redirect_beats_stall;
    test_hz_stall;
    test_wait_mem;
    test_back_to_back;
    test_halt;
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
